apb_master_arbiter: RTL
=======================

Name: apb_master_arbiter

Overview:
- Shares one APB3 completer port (the config register block) between NUM_REQ local requesters.
- Each requester issues a valid/ready request (read or write). The block picks one by round-robin and runs the APB SETUP/ACCESS sequence as APB master.
- It returns read data and error status to the granted requester.
- A timeout guards against a completer that never asserts PREADY.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width
- TIMEOUT, 16, maximum ACCESS cycles without PREADY before a forced error; 0 disables the timeout

Ports:
- PCLK  in  1  clock
- PRESET  in  1  reset (synchronous, active-high)
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept strobe
- req_write  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at slice [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing
- rsp_valid  out  NUM_REQ  one-cycle completion strobe to the owning requester
- rsp_rdata  out  DATA_W  shared response data
- rsp_err  out  1  shared response error
- PSEL, PENABLE, PWRITE  out  1  APB master controls
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY, PSLVERR  in  1  APB completer status

Behaviour:
- Interface: one clock, PCLK; reset PRESET is synchronous and active-high.
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, RR pointer=0, state=IDLE.
- req_ready is combinational and forced to 0 while PRESET=1.
- State machine IDLE -> SETUP -> ACCESS -> IDLE.
- IDLE:
  - If any req_valid is high, grant g = first valid index at or after the RR pointer, wrapping modulo NUM_REQ.
  - req_ready[g]=1 in that same cycle; the handshake completes.
  - Capture req_addr[g], req_wdata[g] and req_write[g] into PADDR/PWDATA/PWRITE at the edge.
  - At the same edge: RR pointer := (g+1) mod NUM_REQ, store g, go to SETUP.
  - No valid request: all outputs hold and PSEL stays 0.
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - On the first cycle with PREADY=1: capture PRDATA (or 0 if PWRITE=1) into rsp_rdata and PSLVERR into rsp_err.
  - Clear PSEL/PENABLE, pulse rsp_valid[g] for the next cycle only, and return to IDLE.
- Timeout (TIMEOUT>0):
  - The wait counter counts ACCESS cycles with PREADY=0.
  - When it reaches TIMEOUT, abort: PSEL/PENABLE -> 0, rsp_rdata=0, rsp_err=1, rsp_valid[g] pulses, state -> IDLE.
  - The counter clears on entry to SETUP.
  - Counter width is $clog2(TIMEOUT+1).
- Hold rules:
  - PADDR, PWRITE and PWDATA are stable from SETUP through the end of ACCESS.
  - After completion they hold their last values. PSEL is never high in IDLE.
- Latency:
  - Accept at cycle T; SETUP at T+1; ACCESS at T+2.
  - With PREADY=1 at T+2, rsp_valid is at T+3.
  - A new accept is allowed at T+3, in the same cycle as rsp_valid, so the minimum period is 3 cycles per transfer.
- Simultaneous events:
  - Requests arriving during SETUP/ACCESS wait; req_ready stays 0 for all requesters.
  - A requester may drop req_valid before it is granted. A pending request is not required to remain valid.
- Reset mid-operation: state returns to IDLE at the next edge and PSEL/PENABLE=0. No rsp_valid is issued for the aborted transfer, and the RR pointer returns to 0.
- At most one rsp_valid bit is high at a time; rsp_rdata and rsp_err are meaningful only while rsp_valid is high.

Decomposition:
- Package apb_pkg holds:
  - enum apb_mst_state_e {IDLE, SETUP, ACCESS}
  - localparam defaults for ADDR_W/DATA_W
  - the timeout-counter width function
- One sub-module, rr_arbiter (NUM_REQ):
  - inputs: req vector, pointer
  - outputs: one-hot grant and grant index
  - purely combinational; the pointer register lives in the parent.

Test Plan:
- Write, PREADY tied 1: req_valid[1]=1, addr=1, wdata=0xA5A50001 at T.
  - Expect req_ready[1] at T, PSEL at T+1, PENABLE at T+2 with PADDR=1 and PWDATA=0xA5A50001.
  - Expect rsp_valid=4'b0010 at T+3, rsp_err=0, rsp_rdata=0.
- Read, PREADY delayed 3 cycles, PRDATA=0x12345678: req0 read addr=0.
  - Expect ACCESS for 4 cycles with PADDR stable, then rsp_valid[0] with rsp_rdata=0x12345678.
- All four req_valid held high, PREADY=1: expect grant order 0,1,2,3,0,1 with accepts every 3 cycles and exactly one rsp_valid bit per completion.
- PSLVERR=1 with PREADY=1 on a read of addr=5 from req2: expect rsp_valid[2], rsp_err=1, rsp_rdata=PRDATA sampled.
- PREADY held 0, TIMEOUT=16: expect PSEL/PENABLE high for 16 ACCESS cycles, then deasserted. rsp_valid pulses with rsp_err=1 and rsp_rdata=0, and the next request is accepted normally.
- PRESET=1 for one cycle during ACCESS of req3:
  - Expect PSEL=PENABLE=0 next cycle and no rsp_valid.
  - Afterwards, with req0 and req3 both valid, req0 is granted first because the pointer was reset to 0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and sizing helpers for the APB master arbiter.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_mst_state_e;

    localparam int APB_ADDR_W_DEF = 32;
    localparam int APB_DATA_W_DEF = 32;

    // Wait-counter width; kept at least one bit so a disabled timeout still elaborates.
    function automatic int tmo_cnt_w(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin sharing of one APB3 completer among NUM_REQ valid/ready requesters,
// with an optional PREADY timeout that completes the transfer with an error.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = APB_ADDR_W_DEF,
    parameter int DATA_W  = APB_DATA_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [DATA_W-1:0]         PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = tmo_cnt_w(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    apb_mst_state_e     state_reg;
    logic [IDX_W-1:0]   ptr_reg;
    logic [IDX_W-1:0]   gidx_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0] grant_onehot;
    logic [IDX_W-1:0]   grant_idx;
    logic               tmo_hit;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (ptr_reg),
        .grant     (grant_onehot),
        .grant_idx (grant_idx)
    );

    // The handshake only exists in IDLE; everyone else waits.
    assign req_ready = (!PRESET && state_reg == IDLE) ? grant_onehot : '0;

    // Last ACCESS cycle allowed without PREADY is the TIMEOUT-th one.
    assign tmo_hit = (TIMEOUT > 0) && (cnt_reg == TMO_LAST);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            gidx_reg  <= '0;
            cnt_reg   <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state_reg)
                IDLE: begin
                    if (|req_valid) begin
                        PADDR     <= addr_arr[grant_idx];
                        PWDATA    <= wdata_arr[grant_idx];
                        PWRITE    <= req_write[grant_idx];
                        gidx_reg  <= grant_idx;
                        ptr_reg   <= (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;
                        cnt_reg   <= '0;
                        PSEL      <= 1'b1;
                        state_reg <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE   <= 1'b1;
                    state_reg <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        rsp_err   <= PSLVERR;
                        rsp_valid <= NUM_REQ'(1) << gidx_reg;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state_reg <= IDLE;
                    end else if (tmo_hit) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= NUM_REQ'(1) << gidx_reg;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
